// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM with memory-wait timeout and trap
module multicycle_controller #(
    parameter int INSTR_W    = 32,
    parameter int TIMEOUT    = 15,
    parameter int CNT_W      = 16,
    parameter int ENABLE_BNE = 1,
    parameter int ENABLE_IMM = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [3:0]         State,
    output logic               Debug,
    output logic               Timeout,
    output logic [CNT_W-1:0]   Retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state, next_state;
    logic [WCW-1:0]   wait_cnt;
    logic [5:0]       opcode;
    logic             expired;
    logic             set_debug, set_timeout, retire;
    logic             unused_bits;

    logic       c_iord, c_memread, c_memwrite, c_irwrite, c_pcwrite;
    logic       c_regdst, c_memtoreg, c_regwrite, c_alusrca;
    logic [1:0] c_alusrcb, c_aluop, c_pcsource;

    assign opcode      = Instruction[INSTR_W-1 -: 6];
    assign unused_bits = ^Instruction[INSTR_W-7:0];
    assign expired     = (wait_cnt == WCW'(TIMEOUT));

    always_comb begin
        next_state  = state;
        set_debug   = 1'b0;
        set_timeout = 1'b0;
        retire      = 1'b0;
        c_iord      = 1'b0;
        c_memread   = 1'b0;
        c_memwrite  = 1'b0;
        c_irwrite   = 1'b0;
        c_pcwrite   = 1'b0;
        c_regdst    = 1'b0;
        c_memtoreg  = 1'b0;
        c_regwrite  = 1'b0;
        c_alusrca   = 1'b0;
        c_alusrcb   = 2'b00;
        c_aluop     = 2'b00;
        c_pcsource  = 2'b00;
        case (state)
            S_FETCH: begin
                c_memread = 1'b1;
                c_alusrcb = 2'b01;
                c_irwrite = MemReady;
                c_pcwrite = MemReady;
                if (MemReady) begin
                    next_state = S_DECODE;
                end else if (expired) begin
                    next_state  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                c_alusrcb = 2'b11;
                case (opcode)
                    OP_RTYPE:      next_state = S_EXEC;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_BNE:        next_state = (ENABLE_BNE != 0) ? S_BRANCH : S_TRAP;
                    OP_J:          next_state = S_JUMP;
                    OP_ADDI:       next_state = (ENABLE_IMM != 0) ? S_IEXEC : S_TRAP;
                    default:       next_state = S_TRAP;
                endcase
                set_debug = (next_state == S_TRAP);
            end
            S_MEMADR: begin
                c_alusrca  = 1'b1;
                c_alusrcb  = 2'b10;
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c_memread = 1'b1;
                c_iord    = 1'b1;
                if (MemReady) begin
                    next_state = S_MEMWB;
                end else if (expired) begin
                    next_state  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_MEMWB: begin
                c_regwrite = 1'b1;
                c_memtoreg = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                c_memwrite = 1'b1;
                c_iord     = 1'b1;
                if (MemReady) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end else if (expired) begin
                    next_state  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_EXEC: begin
                c_alusrca  = 1'b1;
                c_aluop    = 2'b10;
                next_state = S_RWB;
            end
            S_RWB: begin
                c_regwrite = 1'b1;
                c_regdst   = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                c_alusrca  = 1'b1;
                c_aluop    = 2'b01;
                c_pcsource = 2'b01;
                c_pcwrite  = (opcode == OP_BNE) ? ~Zero : Zero;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_JUMP: begin
                c_pcwrite  = 1'b1;
                c_pcsource = 2'b10;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_IEXEC: begin
                c_alusrca  = 1'b1;
                c_alusrcb  = 2'b10;
                c_aluop    = 2'b11;
                next_state = S_IWB;
            end
            S_IWB: begin
                c_regwrite = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default: next_state = S_TRAP;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            Retired  <= '0;
            Debug    <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            state <= next_state;
            // Any state change restarts the wait count; only wait states self-loop besides TRAP
            if (next_state != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEMRD || state == S_MEMWR)
                wait_cnt <= wait_cnt + WCW'(1);
            if (retire)
                Retired <= Retired + CNT_W'(1);
            Debug   <= Debug | set_debug;
            Timeout <= Timeout | set_timeout;
        end
    end

    // Controls are squelched during reset even though the reset state is FETCH
    assign {IorD, MemRead, MemWrite, IRWrite, PCWrite, RegDst, MemtoReg, RegWrite,
            ALUSrcA, ALUSrcB, ALUOp, PCSource} = Rst_n ?
           {c_iord, c_memread, c_memwrite, c_irwrite, c_pcwrite, c_regdst, c_memtoreg,
            c_regwrite, c_alusrca, c_alusrcb, c_aluop, c_pcsource} : 15'd0;
    assign State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic [31:0] Instruction = '0;

    wire [14:0] c0, c1;
    wire [3:0]  st0, st1;
    wire        dbg0, dbg1, to0, to1;
    wire [15:0] ret0;
    wire [1:0]  ret1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        int          d;
        logic [3:0]  st;
        logic [14:0] ctl;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    multicycle_controller dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(Instruction), .Zero(Zero), .MemReady(MemReady),
        .IorD(c0[14]), .MemRead(c0[13]), .MemWrite(c0[12]), .IRWrite(c0[11]), .PCWrite(c0[10]),
        .RegDst(c0[9]), .MemtoReg(c0[8]), .RegWrite(c0[7]), .ALUSrcA(c0[6]), .ALUSrcB(c0[5:4]),
        .ALUOp(c0[3:2]), .PCSource(c0[1:0]), .State(st0), .Debug(dbg0), .Timeout(to0),
        .Retired(ret0)
    );

    multicycle_controller #(.TIMEOUT(3), .CNT_W(2), .ENABLE_BNE(0), .ENABLE_IMM(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(Instruction), .Zero(Zero), .MemReady(MemReady),
        .IorD(c1[14]), .MemRead(c1[13]), .MemWrite(c1[12]), .IRWrite(c1[11]), .PCWrite(c1[10]),
        .RegDst(c1[9]), .MemtoReg(c1[8]), .RegWrite(c1[7]), .ALUSrcA(c1[6]), .ALUSrcB(c1[5:4]),
        .ALUOp(c1[3:2]), .PCSource(c1[1:0]), .State(st1), .Debug(dbg1), .Timeout(to1),
        .Retired(ret1)
    );

    function automatic logic [14:0] model(input logic [3:0] s, input logic mr, input logic z,
                                          input logic [5:0] op);
        logic iord, mrd, mwr, irw, pcw, rdst, m2r, rw, sa;
        logic [1:0] sbv, ao, ps;
        {iord, mrd, mwr, irw, pcw, rdst, m2r, rw, sa} = '0;
        sbv = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            4'd0:  begin mrd = 1; sbv = 2'b01; irw = mr; pcw = mr; end
            4'd1:  sbv = 2'b11;
            4'd2:  begin sa = 1; sbv = 2'b10; end
            4'd3:  begin iord = 1; mrd = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin iord = 1; mwr = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = (op == BNE) ? ~z : z; end
            4'd9:  begin pcw = 1; ps = 2'b10; end
            4'd10: begin sa = 1; sbv = 2'b10; ao = 2'b11; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {iord, mrd, mwr, irw, pcw, rdst, m2r, rw, sa, sbv, ao, ps};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_top();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".state"}, 32'((e.d == 0) ? st0 : st1), 32'(e.st));
        chk({e.tag, ".ctl"},   32'((e.d == 0) ? c0 : c1),   32'(e.ctl));
    endtask

    // trace holds one state per nibble, first cycle in the top nibble; mrp bit i is MemReady in cycle i
    task automatic seq(input int d, input logic [5:0] op, input logic z, input logic [7:0] mrp,
                       input int n, input logic [31:0] trace, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            Instruction = {op, 26'h0};
            Zero        = z;
            MemReady    = mrp[i];
            e.tag = $sformatf("%s[%0d]", tag, i);
            e.d   = d;
            e.st  = trace[31-4*i -: 4];
            e.ctl = model(e.st, mrp[i], z, op);
            sb.push_back(e);
            #1;
            check_top();
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        Rst_n = 1'b0;
        #1;
        chk({tag, ".st0"}, 32'(st0), 0);
        chk({tag, ".ctl0"}, 32'(c0), 0);
        chk({tag, ".flags0"}, {30'd0, dbg0, to0}, 0);
        chk({tag, ".ret0"}, 32'(ret0), 0);
        chk({tag, ".st1"}, 32'(st1), 0);
        chk({tag, ".ctl1"}, 32'(c1), 0);
        chk({tag, ".flags1"}, {30'd0, dbg1, to1}, 0);
        chk({tag, ".ret1"}, 32'(ret1), 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        do_reset("rst_a");

        seq(0, LW,  1'b0, 8'hFF, 5, 32'h01234000, "lw");
        seq(0, SW,  1'b0, 8'hFF, 4, 32'h01250000, "sw");
        seq(0, RT,  1'b0, 8'hFF, 4, 32'h01670000, "add");
        seq(0, BEQ, 1'b1, 8'hFF, 3, 32'h01800000, "beq");
        seq(0, JMP, 1'b0, 8'hFF, 3, 32'h01900000, "j");
        chk("retired5", 32'(ret0), 5);

        seq(0, BNE, 1'b1, 8'hFF, 3, 32'h01800000, "bne_z1");
        seq(0, BNE, 1'b0, 8'hFF, 3, 32'h01800000, "bne_z0");
        chk("retired7", 32'(ret0), 7);

        do_reset("rst_b");
        seq(1, BNE, 1'b0, 8'hFF, 4, 32'h01CC0000, "bne_off");
        chk("bne_off.debug", 32'(dbg1), 1);

        do_reset("rst_c");
        seq(0, RT, 1'b0, 8'hF8, 7, 32'h00001670, "fetch_wait");
        chk("fetch_wait.ret", 32'(ret0), 1);
        chk("fetch_wait.to", 32'(to0), 0);

        do_reset("rst_d");
        seq(1, RT, 1'b0, 8'h00, 5, 32'h0000C000, "fetch_to");
        chk("fetch_to.to", 32'(to1), 1);
        chk("fetch_to.dbg", 32'(dbg1), 0);
        chk("fetch_to.ret", 32'(ret1), 0);

        do_reset("rst_e");
        seq(1, LW, 1'b0, 8'hC7, 8, 32'h01233334, "memrd_edge");
        seq(1, LW, 1'b0, 8'h00, 1, 32'h00000000, "memrd_edge_fetch");
        chk("memrd_edge.to", 32'(to1), 0);
        chk("memrd_edge.ret", 32'(ret1), 1);

        do_reset("rst_f");
        seq(0, ILL, 1'b0, 8'hFF, 5, 32'h01CCC000, "illegal");
        chk("illegal.debug", 32'(dbg0), 1);
        chk("illegal.ret", 32'(ret0), 0);
        do_reset("rst_g");

        for (int i = 0; i < 5; i++) begin
            seq(1, ADDI, 1'b0, 8'hFF, 4, 32'h01AB0000, $sformatf("addi%0d", i));
            chk($sformatf("addi%0d.ret", i), 32'(ret1), 32'((i + 1) % 4));
        end

        seq(1, LW, 1'b0, 8'h07, 5, 32'h01233000, "lw_abort");
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async.state", 32'(st1), 0);
        chk("async.ret", 32'(ret1), 0);
        chk("async.ctl", 32'(c1), 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
